// File: rtl/std_mem_d1_walker.sv
// std_mem_d1_walker
//   Initiator-side engine for a std_mem_d1 (write_en/done) memory. On a go
//   request it walks a contiguous, wrapping address range of one 1-D memory:
//     mode 0 (read): sums the entries through the combinational read port.
//     mode 1 (fill): writes fill_value, fill_value+fill_step, ... waiting for
//                    mem_done after every write.
//   All outputs are registered. Reset is synchronous, active-high.
//
// Optional feature macro: STD_WALKER_TIMEOUT_EN
//   Defined:   a wait counter aborts a write after TIMEOUT cycles without
//              mem_done, finishing with error=1 (held until next go/reset).
//   Undefined: no counter; error stays 0 and the walker waits indefinitely.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   go                start request, sampled only when idle
//   mode              0 = read/sum, 1 = fill (sampled with go)
//   start_addr        first address (sampled with go)
//   count             number of entries, 0..SIZE (sampled with go)
//   fill_value        first fill word (sampled with go)
//   fill_step         fill increment per word (sampled with go)
//   done              one-cycle completion pulse
//   sum               read-mode result, held until next go
//   error             timeout abort flag, valid with done
//   addr0             memory address
//   write_data        memory write word
//   write_en          memory write strobe
//   read_data         memory combinational read data
//   mem_done          memory write acknowledge (one cycle after write_en)
module std_mem_d1_walker #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SIZE      = 16,
  parameter int unsigned IDX_SIZE  = 4,
  parameter int unsigned SUM_WIDTH = 32,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 mode,
  input  logic [IDX_SIZE-1:0]  start_addr,
  input  logic [IDX_SIZE:0]    count,
  input  logic [WIDTH-1:0]     fill_value,
  input  logic [WIDTH-1:0]     fill_step,
  output logic                 done,
  output logic [SUM_WIDTH-1:0] sum,
  output logic                 error,
  output logic [IDX_SIZE-1:0]  addr0,
  output logic [WIDTH-1:0]     write_data,
  output logic                 write_en,
  input  logic [WIDTH-1:0]     read_data,
  input  logic                 mem_done
);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StWait,
    StFinish
  } state_e;

  state_e                state_q;
  logic [IDX_SIZE:0]     remaining_q;
  logic [WIDTH-1:0]      step_q;
  logic [IDX_SIZE-1:0]   next_addr;
  logic [SUM_WIDTH-1:0]  read_ext;
  logic                  last_entry;

`ifdef STD_WALKER_TIMEOUT_EN
  localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TimerW-1:0] timer_q;
`endif

  // Address wraps at SIZE-1 back to 0, even when SIZE is not a power of two.
  always_comb begin
    next_addr = addr0 + IDX_SIZE'(1);
    if (addr0 == IDX_SIZE'(SIZE - 1)) begin
      next_addr = '0;
    end
  end

  always_comb begin
    read_ext   = SUM_WIDTH'(read_data);
    last_entry = (remaining_q == (IDX_SIZE + 1)'(1));
  end

  // done and write_en are registered: they are raised on the edge that
  // enters FINISH / WRITE so they are high for exactly that state's cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      step_q      <= '0;
      done        <= 1'b0;
      sum         <= '0;
      error       <= 1'b0;
      addr0       <= '0;
      write_data  <= '0;
      write_en    <= 1'b0;
`ifdef STD_WALKER_TIMEOUT_EN
      timer_q     <= '0;
`endif
    end else begin
      done     <= 1'b0;
      write_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (go) begin
            addr0       <= start_addr;
            sum         <= '0;
            error       <= 1'b0;
            write_data  <= fill_value;
            step_q      <= fill_step;
            remaining_q <= count;
            if (count == '0) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else if (mode) begin
              state_q  <= StWrite;
              write_en <= 1'b1;
            end else begin
              state_q <= StRead;
            end
          end
        end

        StRead: begin
          sum         <= sum + read_ext;
          addr0       <= next_addr;
          remaining_q <= remaining_q - (IDX_SIZE + 1)'(1);
          if (last_entry) begin
            state_q <= StFinish;
            done    <= 1'b1;
          end
        end

        StWrite: begin
          state_q <= StWait;
`ifdef STD_WALKER_TIMEOUT_EN
          timer_q <= '0;
`endif
        end

        StWait: begin
          if (mem_done) begin
            addr0       <= next_addr;
            write_data  <= write_data + step_q;
            remaining_q <= remaining_q - (IDX_SIZE + 1)'(1);
            if (last_entry) begin
              state_q <= StFinish;
              done    <= 1'b1;
            end else begin
              state_q  <= StWrite;
              write_en <= 1'b1;
            end
          end
`ifdef STD_WALKER_TIMEOUT_EN
          // mem_done on the final allowed cycle still counts as success.
          else if (timer_q == TimerW'(TIMEOUT - 1)) begin
            state_q <= StFinish;
            done    <= 1'b1;
            error   <= 1'b1;
          end else begin
            timer_q <= timer_q + TimerW'(1);
          end
`endif
        end

        StFinish: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_std_mem_d1_walker.sv
// Self-checking bench for std_mem_d1_walker: a std_mem_d1 responder model,
// a table of directed vectors, hand-written multi-cycle sequences and a
// randomized run checked against a plain-arithmetic reference model.
module tb_std_mem_d1_walker;
  localparam int unsigned WIDTH     = 32;
  localparam int unsigned SIZE      = 16;
  localparam int unsigned IDX_SIZE  = 4;
  localparam int unsigned SUM_WIDTH = 32;
  localparam int unsigned TIMEOUT   = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 go = 1'b0;
  logic                 mode = 1'b0;
  logic [IDX_SIZE-1:0]  start_addr = '0;
  logic [IDX_SIZE:0]    count = '0;
  logic [WIDTH-1:0]     fill_value = '0;
  logic [WIDTH-1:0]     fill_step = '0;
  logic                 done;
  logic [SUM_WIDTH-1:0] sum;
  logic                 error;
  logic [IDX_SIZE-1:0]  addr0;
  logic [WIDTH-1:0]     write_data;
  logic                 write_en;
  logic [WIDTH-1:0]     read_data;
  logic                 mem_done;

  // Responder model
  logic [WIDTH-1:0] mem [SIZE];
  logic             mem_done_q = 1'b0;
  logic             stuck = 1'b0;
  logic             stray = 1'b0;

  assign read_data = mem[addr0];
  assign mem_done  = mem_done_q | stray;

  always @(posedge clk) begin
    if (write_en) mem[addr0] <= write_data;
    mem_done_q <= write_en & ~stuck;
  end

  int wr_count = 0;
  always @(negedge clk) begin
    if (write_en) wr_count <= wr_count + 1;
  end

  always #5 clk = ~clk;

  std_mem_d1_walker #(
    .WIDTH(WIDTH), .SIZE(SIZE), .IDX_SIZE(IDX_SIZE), .SUM_WIDTH(SUM_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .mode(mode), .start_addr(start_addr), .count(count),
    .fill_value(fill_value), .fill_step(fill_step), .done(done), .sum(sum), .error(error),
    .addr0(addr0), .write_data(write_data), .write_en(write_en), .read_data(read_data),
    .mem_done(mem_done)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic preload_ramp();
    for (int i = 0; i < SIZE; i++) mem[i] = 32'(i) - 32'd1;
  endtask

  // Drive go for one edge (E0); returns at the cycle-1 sample point.
  task automatic start_op(input logic m, input int s, input int c, input logic [31:0] v,
                          input logic [31:0] st);
    @(negedge clk);
    go = 1'b1; mode = m; start_addr = IDX_SIZE'(s); count = (IDX_SIZE + 1)'(c);
    fill_value = v; fill_step = st;
    @(posedge clk);
    #1;
    go = 1'b0;
    // Inputs after E0 must be ignored.
    mode = 1'($urandom); start_addr = IDX_SIZE'($urandom); count = (IDX_SIZE + 1)'($urandom);
    fill_value = $urandom; fill_step = $urandom;
  endtask

  // Cycle number (after E0) of the first done sample, or -1 if none in budget.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) cyc = -1;
  endtask

  task automatic run_op(input logic m, input int s, input int c, input logic [31:0] v,
                        input logic [31:0] st, output int cyc, output int writes);
    int base;
    base = wr_count;
    start_op(m, s, c, v, st);
    wait_done(2 * c + 10, cyc);
    writes = wr_count - base;
  endtask

  typedef struct {
    logic        m;
    int          s;
    int          c;
    logic [31:0] v;
    logic [31:0] st;
    logic [31:0] exp_sum;
    int          exp_cyc;
    int          exp_wr;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int cyc, writes, seen;
    logic [31:0] w;

    // mem[i] = i-1 is preloaded before every vector.
    tbl[0] = '{1'b0,  2,  4, 32'd0,        32'd0,        32'd10,  5,  0};
    tbl[1] = '{1'b1,  0,  3, 32'd5,        32'd2,        32'd0,   7,  3};
    tbl[2] = '{1'b0,  6,  0, 32'd0,        32'd0,        32'd0,   1,  0};
    tbl[3] = '{1'b1,  9,  0, 32'd7,        32'd1,        32'd0,   1,  0};
    tbl[4] = '{1'b1, 14,  4, 32'd0,        32'd1,        32'd0,   9,  4};
    tbl[5] = '{1'b0, 14,  4, 32'd0,        32'd0,        32'd26,  5,  0};
    tbl[6] = '{1'b0,  0, 16, 32'd0,        32'd0,        32'd104, 17, 0};
    tbl[7] = '{1'b1,  7, 16, 32'hFFFFFFFF, 32'h80000000, 32'd0,   33, 16};
    tbl[8] = '{1'b0, 15,  1, 32'd0,        32'd0,        32'd14,  2,  0};

    preload_ramp();
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", done, 0);
    check("reset_sum", sum, 0);
    check("reset_error", error, 0);
    check("reset_addr0", addr0, 0);
    check("reset_write_data", write_data, 0);
    check("reset_write_en", write_en, 0);
    reset = 1'b0;

    // Directed table
    foreach (tbl[i]) begin
      preload_ramp();
      run_op(tbl[i].m, tbl[i].s, tbl[i].c, tbl[i].v, tbl[i].st, cyc, writes);
      check($sformatf("tbl%0d_done_cycle", i), 64'(cyc), 64'(tbl[i].exp_cyc));
      check($sformatf("tbl%0d_sum", i), sum, tbl[i].exp_sum);
      check($sformatf("tbl%0d_writes", i), 64'(writes), 64'(tbl[i].exp_wr));
      check($sformatf("tbl%0d_error", i), error, 0);
      if (tbl[i].m) begin
        for (int k = 0; k < tbl[i].c; k++) begin
          w = tbl[i].v + 32'(k) * tbl[i].st;
          check($sformatf("tbl%0d_mem%0d", i, (tbl[i].s + k) % SIZE),
                mem[(tbl[i].s + k) % SIZE], w);
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d_done_pulse", i), done, 0);
    end

    // go held high: count=0 restarts only after returning to IDLE.
    @(negedge clk);
    go = 1'b1; mode = 1'b0; count = '0;
    @(posedge clk); #1;
    check("gohold_c1", done, 1);
    @(posedge clk); #1;
    check("gohold_c2", done, 0);
    @(posedge clk); #1;
    check("gohold_c3", done, 1);
    go = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after 2 of 5 fill words.
    preload_ramp();
    start_op(1'b1, 3, 5, 32'd100, 32'd10);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_done", done, 0);
    check("rst_mid_sum", sum, 0);
    check("rst_mid_error", error, 0);
    check("rst_mid_addr0", addr0, 0);
    check("rst_mid_write_data", write_data, 0);
    check("rst_mid_write_en", write_en, 0);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || write_en) seen++;
    end
    check("rst_mid_quiet", 64'(seen), 0);
    check("rst_mid_mem3", mem[3], 32'd100);
    check("rst_mid_mem4", mem[4], 32'd110);
    check("rst_mid_mem5", mem[5], 32'd4);

    // mem_done stuck low.
    preload_ramp();
    stuck = 1'b1;
`ifdef STD_WALKER_TIMEOUT_EN
    run_op(1'b1, 0, 1, 32'hAB, 32'd0, cyc, writes);
    check("timeout_cycle", 64'(cyc), 64'(TIMEOUT + 2));
    check("timeout_error", error, 1);
    check("timeout_writes", 64'(writes), 1);
    check("timeout_mem0", mem[0], 32'hAB);
    @(posedge clk); #1;
    check("timeout_done_pulse", done, 0);
    check("timeout_error_hold", error, 1);
    stuck = 1'b0;
    start_op(1'b0, 0, 0, 32'd0, 32'd0);
    check("timeout_error_clear", error, 0);
    @(posedge clk); #1;
`else
    begin
      int base;
      base = wr_count;
      start_op(1'b1, 0, 1, 32'hAB, 32'd0);
      seen = 0;
      repeat (100) begin
        @(posedge clk); #1;
        if (done) seen++;
      end
      check("nowait_done", 64'(seen), 0);
      check("nowait_error", error, 0);
      check("nowait_writes", 64'(wr_count - base), 1);
      check("nowait_addr0", addr0, 0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stuck = 1'b0;
    @(posedge clk); #1;
`endif

    // Randomized run against a reference model.
    for (int it = 0; it < 40; it++) begin
      logic        m;
      int          s, c, exp_cyc, nbad;
      logic [31:0] v, st, exp_sum;
      logic [31:0] exp_mem [SIZE];
      m  = 1'($urandom_range(0, 1));
      s  = $urandom_range(0, SIZE - 1);
      c  = $urandom_range(0, SIZE);
      v  = $urandom;
      st = $urandom;
      for (int i = 0; i < SIZE; i++) begin
        mem[i] = $urandom;
        exp_mem[i] = mem[i];
      end
      exp_sum = '0;
      for (int k = 0; k < c; k++) begin
        if (m) exp_mem[(s + k) % SIZE] = v + 32'(k) * st;
        else   exp_sum += mem[(s + k) % SIZE];
      end
      exp_cyc = (c == 0) ? 1 : (m ? 2 * c + 1 : c + 1);
      stray = m ? 1'b0 : 1'($urandom_range(0, 1));
      run_op(m, s, c, v, st, cyc, writes);
      stray = 1'b0;
      check($sformatf("rand%0d_done_cycle", it), 64'(cyc), 64'(exp_cyc));
      check($sformatf("rand%0d_sum", it), sum, m ? 32'd0 : exp_sum);
      check($sformatf("rand%0d_writes", it), 64'(writes), m ? 64'(c) : 64'd0);
      nbad = 0;
      for (int i = 0; i < SIZE; i++) if (mem[i] !== exp_mem[i]) nbad++;
      check($sformatf("rand%0d_mem", it), 64'(nbad), 0);
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
